div_radix2_unit: RTL

Multi-cycle radix-2 restoring divider for DIV/DIVU, attached to the Execute stage. It registers the E-stage source operands (SrcAE/SrcBE) on start and delivers {remainder, quotient} for the HI/LO write path. It drives a stall request so the hazard unit freezes F/D/E until the result is ready.

---
 rtl/div_radix2_unit.sv | 122 ++++++++++++
 1 files changed

// File: rtl/div_radix2_unit.sv
// div_radix2_unit: multi-cycle radix-2 restoring divider (DIV/DIVU) for the
// Execute stage. Produces {remainder, quotient} for HI/LO and requests a
// pipeline stall while an operation is outstanding.
// Optional feature macro: DIV_EARLY_OUT_EN -- finish in one cycle when
// |dividend| < |divisor| (same results, shorter latency).
module div_radix2_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stall_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] rem;      // partial remainder
  logic [WIDTH-1:0] dvd;      // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] dvs;      // divisor magnitude
  logic [CW-1:0]    cnt;
  logic             q_neg, r_neg;

  // Operand magnitudes and sign flags, taken straight from the E-stage sources
  logic             a_neg, b_neg, go, div_zero, early;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign go       = start_i & ~annul_i;
  assign a_neg    = signed_div_i & opdata1_i[WIDTH-1];
  assign b_neg    = signed_div_i & opdata2_i[WIDTH-1];
  assign a_mag    = a_neg ? -opdata1_i : opdata1_i;
  assign b_mag    = b_neg ? -opdata2_i : opdata2_i;
  assign div_zero = (opdata2_i == '0);
`ifdef DIV_EARLY_OUT_EN
  assign early    = (a_mag < b_mag);
`else
  assign early    = 1'b0;
`endif

  // One restoring step: trial subtract is one bit wider so its sign is the borrow
  logic [WIDTH:0]   rem_sh, diff;
  logic             qbit, last;
  logic [WIDTH-1:0] rem_nxt, dvd_nxt, q_fix, r_fix;

  assign rem_sh  = {rem, dvd[WIDTH-1]};
  assign diff    = rem_sh - {1'b0, dvs};
  assign qbit    = ~diff[WIDTH];
  assign rem_nxt = qbit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign dvd_nxt = {dvd[WIDTH-2:0], qbit};
  assign last    = (cnt == CW'(WIDTH - 1));
  assign q_fix   = q_neg ? -dvd_nxt : dvd_nxt;
  assign r_fix   = r_neg ? -rem_nxt : rem_nxt;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and ready decode
  always_comb begin
    state_nxt = state;
    ready_o   = 1'b0;
    case (state)
      IDLE: if (go) state_nxt = (div_zero || early) ? DONE : BUSY;
      BUSY: begin
        if (annul_i)   state_nxt = IDLE;
        else if (last) state_nxt = DONE;
      end
      DONE: begin
        ready_o   = ~annul_i;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign stall_o = start_i & ~ready_o & ~annul_i;

  // Datapath: operand capture, iteration, and sign-fixed result load into DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      rem      <= '0;
      dvd      <= '0;
      dvs      <= '0;
      cnt      <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      result_o <= '0;
    end else begin
      case (state)
        IDLE: if (go) begin
          rem   <= '0;
          dvd   <= a_mag;
          dvs   <= b_mag;
          cnt   <= '0;
          q_neg <= a_neg ^ b_neg;
          r_neg <= a_neg;
          // Short-circuit cases keep the original dividend as remainder
          if (div_zero)   result_o <= {opdata1_i, {WIDTH{1'b1}}};
          else if (early) result_o <= {opdata1_i, {WIDTH{1'b0}}};
        end
        BUSY: begin
          rem <= rem_nxt;
          dvd <= dvd_nxt;
          cnt <= cnt + CW'(1);
          if (last && !annul_i) result_o <= {r_fix, q_fix};
        end
        default: ;
      endcase
    end
  end

endmodule
